// File: rtl/fsm_cc8_sched_if.sv
// Command/engine bundle between the two requesters, the cc8 scheduler and the engine.
interface fsm_cc8_sched_if;
    logic       req0;
    logic       req1;
    logic [2:0] cmd0;
    logic [2:0] cmd1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       busy;
    logic       err;
    logic       eng_go;
    logic       eng_jmp;
    logic       eng_sk0;
    logic       eng_sk1;
    logic       eng_y1;
    logic       eng_y2;
    logic       eng_y3;

    modport slave (
        input  req0, req1, cmd0, cmd1,
        input  eng_y1, eng_y2, eng_y3,
        output gnt0, gnt1, done0, done1, busy, err,
        output eng_go, eng_jmp, eng_sk0, eng_sk1
    );

    modport master (
        output req0, req1, cmd0, cmd1,
        output eng_y1, eng_y2, eng_y3,
        input  gnt0, gnt1, done0, done1, busy, err,
        input  eng_go, eng_jmp, eng_sk0, eng_sk1
    );
endinterface

// File: rtl/fsm_cc8_sched.sv
// Round-robin two-requester launcher for the cc8 engine with end-of-run detection.
// Optional run watchdog enabled by defining FSM_SCHED_WDOG_EN.
module fsm_cc8_sched #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    fsm_cc8_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

    state_t     state;
    logic       last;
    logic       owner;
    logic       seen111;
    logic       hold111;
    logic [2:0] cmd_q;
    logic       gnt0_q, gnt1_q, done0_q, done1_q;
    logic       busy_q, err_q;
    logic       go_q, jmp_q, sk0_q, sk1_q;

    logic [2:0] y;
    logic       any_req;
    logic       win;
    logic [2:0] win_cmd;
    logic       wd_hit;

    assign y       = {bus.eng_y1, bus.eng_y2, bus.eng_y3};
    assign any_req = bus.req0 | bus.req1;
    // On a tie the requester not served last wins
    assign win     = (bus.req0 & bus.req1) ? ~last : bus.req1;
    assign win_cmd = win ? bus.cmd1 : bus.cmd0;

`ifdef FSM_SCHED_WDOG_EN
    logic [CW-1:0] wd;
    assign wd_hit = (wd == CW'(TIMEOUT - 1));
`else
    assign wd_hit = 1'b0 & (TIMEOUT > 0) & (CW > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            owner   <= 1'b0;
            seen111 <= 1'b0;
            hold111 <= 1'b0;
            cmd_q   <= 3'b000;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            go_q    <= 1'b0;
            jmp_q   <= 1'b0;
            sk0_q   <= 1'b0;
            sk1_q   <= 1'b0;
`ifdef FSM_SCHED_WDOG_EN
            wd      <= '0;
`endif
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt0_q <= ~win;
                        gnt1_q <= win;
                        owner  <= win;
                        last   <= win;
                        cmd_q  <= win_cmd;
                        busy_q <= 1'b1;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    go_q    <= 1'b1;
                    jmp_q   <= cmd_q[2];
                    sk1_q   <= cmd_q[1];
                    sk0_q   <= cmd_q[0];
                    seen111 <= 1'b0;
                    hold111 <= 1'b0;
`ifdef FSM_SCHED_WDOG_EN
                    wd      <= '0;
`endif
                    state   <= RUN;
                end
                RUN: begin
                    jmp_q <= 1'b0;
`ifdef FSM_SCHED_WDOG_EN
                    wd    <= wd + 1'b1;
`endif
                    if (wd_hit) begin
                        err_q   <= 1'b1;
                        done0_q <= ~owner;
                        done1_q <= owner;
                        go_q    <= 1'b0;
                        sk0_q   <= 1'b0;
                        sk1_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (seen111 && y == 3'b000) begin
                        done0_q <= ~owner;
                        done1_q <= owner;
                        go_q    <= 1'b0;
                        sk0_q   <= 1'b0;
                        sk1_q   <= 1'b0;
                        state   <= DONE;
                    end else begin
                        seen111 <= seen111 | (y == 3'b111);
                        // A 111 sample taken while go is high does not count
                        if (go_q) begin
                            go_q    <= 1'b0;
                            hold111 <= 1'b0;
                        end else if (y == 3'b111) begin
                            go_q    <= hold111;
                            hold111 <= ~hold111;
                        end else begin
                            hold111 <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;
    assign bus.eng_go  = go_q;
    assign bus.eng_jmp = jmp_q;
    assign bus.eng_sk0 = sk0_q;
    assign bus.eng_sk1 = sk1_q;

endmodule

// File: tb/tb_fsm_cc8_sched.sv
// Directed bench for fsm_cc8_sched with a small behavioural cc8 engine model.
module tb_fsm_cc8_sched;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    fsm_cc8_sched_if bus ();

    fsm_cc8_sched #(.TIMEOUT(8), .CW(7)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {E_IDLE, E_S1, E_S2, E_S6, E_S7, E_HOLD, E_S9} es_t;
    es_t        es;
    logic [2:0] eng_y;
    logic       y_ovr;
    logic [2:0] y_frc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) es <= E_IDLE;
        else begin
            case (es)
                E_IDLE: if (bus.eng_go) es <= bus.eng_jmp ? E_S6 : E_S1;
                E_S1:   es <= E_S2;
                E_S2:   es <= bus.eng_sk0 ? E_HOLD : E_S9;
                E_HOLD: if (bus.eng_go) es <= E_S9;
                E_S6:   es <= E_S7;
                E_S7:   es <= E_S9;
                E_S9:   es <= E_IDLE;
                default: es <= E_IDLE;
            endcase
        end
    end

    always_comb begin
        eng_y = 3'b000;
        case (es)
            E_S1:   eng_y = 3'b001;
            E_S2:   eng_y = 3'b010;
            E_S6:   eng_y = 3'b110;
            E_S7:   eng_y = 3'b011;
            E_HOLD: eng_y = 3'b111;
            E_S9:   eng_y = 3'b111;
            default: eng_y = 3'b000;
        endcase
    end

    assign {bus.eng_y1, bus.eng_y2, bus.eng_y3} = y_ovr ? y_frc : eng_y;

    logic [9:0] outs;
    assign outs = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy,
                   bus.err, bus.eng_go, bus.eng_jmp, bus.eng_sk0, bus.eng_sk1};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int kicks, kick_c, done_c, gid, lows, errs, k, ng;
        logic ok;
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = 3'b000;
        bus.cmd1 = 3'b000;
        y_ovr = 1'b0;
        y_frc = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        tick();

        // single request, cmd 000: minimum latency
        bus.req0 = 1'b1;
        tick();
        check("t1_gnt0", 32'({bus.gnt0, bus.gnt1, bus.busy}), 32'b101);
        bus.req0 = 1'b0;
        tick();
        check("t1_go_c2", 32'(bus.eng_go), 32'd1);
        tick();
        check("t1_go_c3", 32'(bus.eng_go), 32'd0);
        repeat (3) tick();
        check("t1_done_c6", 32'(bus.done0), 32'd0);
        tick();
        check("t1_done_c7", 32'({bus.done0, bus.done1, bus.busy}), 32'b101);
        tick();
        check("t1_busy_c8", 32'({bus.done0, bus.busy}), 32'b00);

        // jump command from requester 1
        bus.cmd1 = 3'b100;
        bus.req1 = 1'b1;
        tick();
        check("t3_gnt1", 32'({bus.gnt0, bus.gnt1}), 32'b01);
        bus.req1 = 1'b0;
        tick();
        check("t3_jmp_c2", 32'({bus.eng_go, bus.eng_jmp}), 32'b11);
        tick();
        check("t3_jmp_c3", 32'({bus.eng_go, bus.eng_jmp}), 32'b00);
        check("t3_y110", 32'({bus.eng_y1, bus.eng_y2, bus.eng_y3}), 32'b110);
        repeat (3) tick();
        check("t3_done_c6", 32'(bus.done1), 32'd0);
        tick();
        check("t3_done_c7", 32'({bus.done0, bus.done1}), 32'b01);
        tick();

        // skip into the hold state: exactly one kick
        bus.cmd0 = 3'b001;
        bus.req0 = 1'b1;
        tick();
        check("t4_gnt0", 32'(bus.gnt0), 32'd1);
        bus.req0 = 1'b0;
        tick();
        check("t4_sk0_c2", 32'({bus.eng_go, bus.eng_sk0}), 32'b11);
        kicks = 0;
        kick_c = 0;
        done_c = 0;
        for (int c = 3; c <= 12; c++) begin
            tick();
            if (bus.eng_go) begin
                kicks++;
                kick_c = c;
            end
            if (bus.done0) done_c = c;
            if (c == 5) check("t4_sk0_held", 32'(bus.eng_sk0), 32'd1);
        end
        check("t4_kicks", 32'(kicks), 32'd1);
        check("t4_kick_cyc", 32'(kick_c), 32'd7);
        check("t4_done_cyc", 32'(done_c), 32'd10);
        check("t4_sk0_after", 32'(bus.eng_sk0), 32'd0);

        // reset three cycles into a run
        bus.cmd0 = 3'b000;
        bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        repeat (2) tick();
        check("t5_go_before_rst", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_outs", 32'(outs), 32'd0);
        tick();
        check("t5_rst_hold", 32'({outs, bus.eng_y1, bus.eng_y2, bus.eng_y3}), 32'd0);
        rst_n = 1'b1;

        // both held: strict alternation starting with 0
        bus.cmd0 = 3'b000;
        bus.cmd1 = 3'b000;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            ok = 1'b0;
            k = 0;
            while (!ok && k < 20) begin
                tick();
                k++;
                if (bus.done0 || bus.done1)
                    check("t2_stray_done", 32'({bus.done0, bus.done1}), 32'd0);
                if (bus.gnt0 || bus.gnt1) ok = 1'b1;
            end
            check($sformatf("t2_gnt_seen_%0d", r), 32'(ok), 32'd1);
            check($sformatf("t2_gnt_id_%0d", r), 32'({bus.gnt0, bus.gnt1}),
                  (r % 2 == 0) ? 32'b10 : 32'b01);
            gid = bus.gnt1 ? 1 : 0;
            ok = 1'b0;
            k = 0;
            ng = 0;
            while (!ok && k < 30) begin
                tick();
                k++;
                if (bus.gnt0 || bus.gnt1) ng++;
                if (bus.done0 || bus.done1) ok = 1'b1;
            end
            check($sformatf("t2_done_seen_%0d", r), 32'(ok), 32'd1);
            check($sformatf("t2_done_id_%0d", r), 32'({bus.done0, bus.done1}),
                  (gid == 0) ? 32'b10 : 32'b01);
            check($sformatf("t2_overlap_%0d", r), 32'(ng), 32'd0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (3) tick();
        check("t2_idle_after", 32'(bus.busy), 32'd0);

        // engine stuck at 010
        y_ovr = 1'b1;
        y_frc = 3'b010;
        bus.req0 = 1'b1;
        tick();
        check("t6_gnt0", 32'(bus.gnt0), 32'd1);
        bus.req0 = 1'b0;
`ifdef FSM_SCHED_WDOG_EN
        repeat (8) tick();
        check("t6_err_c9", 32'({bus.err, bus.done0, bus.busy}), 32'b001);
        tick();
        check("t6_err_c10", 32'({bus.err, bus.done0, bus.busy}), 32'b110);
        tick();
        check("t6_err_c11", 32'({bus.err, bus.done0, bus.busy}), 32'b000);
`else
        lows = 0;
        errs = 0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (!bus.busy) lows++;
            if (bus.err || bus.done0) errs++;
        end
        check("t6_busy_stuck", 32'(lows), 32'd0);
        check("t6_no_err", 32'(errs), 32'd0);
`endif
        y_ovr = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_recover", 32'(outs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
